// File: rtl/alarm_pkg.sv
// ============================================================================
// Module      : alarm_pkg
// Description : Shared state encoding, BCD time type and default timings
//               for the alarm sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  localparam int c_snooze_sec_default       = 300;
  localparam int c_ring_timeout_sec_default = 60;

endpackage

`default_nettype wire

// File: rtl/alarm_slot_match.sv
// ============================================================================
// Module      : alarm_slot_match
// Description : One programmable alarm slot (time + armed flag) and its
//               minute-boundary comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_slot_match
  import alarm_pkg::*;
(
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       wr_en,
  input  bcd_time_t  wr_time,
  input  logic       wr_arm,
  input  bcd_time_t  cur_time,
  input  logic [3:0] cur_s1,
  input  logic [3:0] cur_s0,
  output logic       match
);

  bcd_time_t r_time;
  logic      r_armed;

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_time  <= '0;
      r_armed <= 1'b0;
    end else if (wr_en) begin
      r_time  <= wr_time;
      r_armed <= wr_arm;
    end
  end

  // Only the :00 second fires, so a slot matches at most once per minute.
  assign match = r_armed && (r_time == cur_time) &&
                 (cur_s1 == 4'd0) && (cur_s0 == 4'd0);

endmodule

`default_nettype wire

// File: rtl/alarm_sequencer.sv
// ============================================================================
// Module      : alarm_sequencer
// Description : Multi-slot alarm controller: slot storage, lowest-index
//               arbitration and ring/snooze/stop/timeout sequencing.
//               Optional macro ALARM_MISSED_CNT_EN adds the missed_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS        = 4,
  parameter int SNOOZE_SEC       = c_snooze_sec_default,
  parameter int RING_TIMEOUT_SEC = c_ring_timeout_sec_default,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  input  logic [3:0] cur_s1,
  input  logic [3:0] cur_s0,
  input  logic       wr_en,
  input  logic [2:0] wr_slot,
  input  logic [1:0] wr_h1,
  input  logic [3:0] wr_h0,
  input  logic [3:0] wr_m1,
  input  logic [3:0] wr_m0,
  input  logic       wr_arm,
  input  logic       al_on,
  input  logic       stop_al,
  input  logic       snooze_req,
  output logic       alarm,
  output logic [2:0] active_slot,
  output logic [1:0] state,
  output logic [9:0] snooze_left
`ifdef ALARM_MISSED_CNT_EN
  ,
  output logic [7:0] missed_cnt
`endif
);

  bcd_time_t            w_cur_time;
  bcd_time_t            w_wr_time;
  logic                 w_wr_ok;
  logic [NUM_SLOTS-1:0] w_match;
  logic                 w_any_match;
  logic [2:0]           w_winner;
  logic                 w_snooze_ok;
  logic                 w_ring_expired;

  alarm_state_t r_state, w_state_nx;
  logic [2:0]   r_active_slot, w_active_nx;
  logic [9:0]   r_snooze_left, w_left_nx;
  logic [2:0]   r_snooze_cnt, w_cnt_nx;
  logic [7:0]   r_ring_timer, w_timer_nx;

  assign w_cur_time = '{h1: cur_h1, h0: cur_h0, m1: cur_m1, m0: cur_m0};
  assign w_wr_time  = '{h1: wr_h1, h0: wr_h0, m1: wr_m1, m0: wr_m0};
  assign w_wr_ok    = wr_en && ({1'b0, wr_slot} < 4'(NUM_SLOTS));

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    alarm_slot_match u_slot (
      .clk_1s   (clk_1s),
      .reset    (reset),
      .wr_en    (w_wr_ok && (wr_slot == 3'(g))),
      .wr_time  (w_wr_time),
      .wr_arm   (wr_arm),
      .cur_time (w_cur_time),
      .cur_s1   (cur_s1),
      .cur_s0   (cur_s0),
      .match    (w_match[g])
    );
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    w_winner = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_match[i]) w_winner = 3'(i);
    end
  end

  assign w_any_match    = |w_match;
  assign w_snooze_ok    = snooze_req && (r_snooze_cnt < 3'(MAX_SNOOZE));
  assign w_ring_expired = (r_ring_timer == 8'(RING_TIMEOUT_SEC - 1));

  always_comb begin
    w_state_nx  = r_state;
    w_active_nx = r_active_slot;
    w_left_nx   = r_snooze_left;
    w_cnt_nx    = r_snooze_cnt;
    w_timer_nx  = r_ring_timer;
    if (!al_on) begin
      w_state_nx = IDLE;
      w_left_nx  = 10'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_match) begin
            w_state_nx  = RING;
            w_active_nx = w_winner;
            w_cnt_nx    = 3'd0;
            w_timer_nx  = 8'd0;
          end
        end
        RING: begin
          w_timer_nx = r_ring_timer + 8'd1;
          if (stop_al) begin
            w_state_nx = IDLE;
          end else if (w_snooze_ok) begin
            w_state_nx = SNOOZE;
            w_left_nx  = 10'(SNOOZE_SEC);
            w_cnt_nx   = r_snooze_cnt + 3'd1;
          end else if (w_ring_expired) begin
            w_state_nx = IDLE;
          end
        end
        SNOOZE: begin
          if (stop_al) begin
            w_state_nx = IDLE;
            w_left_nx  = 10'd0;
          end else if (r_snooze_left == 10'd1) begin
            w_state_nx = RING;
            w_timer_nx = 8'd0;
            w_left_nx  = 10'd0;
          end else begin
            w_left_nx = r_snooze_left - 10'd1;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_left_nx  = 10'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_active_slot <= 3'd0;
      r_snooze_left <= 10'd0;
      r_snooze_cnt  <= 3'd0;
      r_ring_timer  <= 8'd0;
    end else begin
      r_state       <= w_state_nx;
      r_active_slot <= w_active_nx;
      r_snooze_left <= w_left_nx;
      r_snooze_cnt  <= w_cnt_nx;
      r_ring_timer  <= w_timer_nx;
    end
  end

  assign alarm       = (r_state == RING);
  assign state       = r_state;
  assign active_slot = r_active_slot;
  assign snooze_left = r_snooze_left;

`ifdef ALARM_MISSED_CNT_EN
  logic       w_timeout;
  logic       w_drop;
  logic [8:0] w_missed_sum;
  logic [7:0] r_missed_cnt;

  // A timeout and a dropped match on the same tick count as two misses.
  assign w_timeout    = al_on && (r_state == RING) && !stop_al && !w_snooze_ok && w_ring_expired;
  assign w_drop       = al_on && (r_state != IDLE) && w_any_match;
  assign w_missed_sum = {1'b0, r_missed_cnt} + 9'(w_timeout) + 9'(w_drop);

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_missed_cnt <= 8'd0;
    end else if (stop_al) begin
      r_missed_cnt <= 8'd0;
    end else if (w_missed_sum > 9'd255) begin
      r_missed_cnt <= 8'd255;
    end else begin
      r_missed_cnt <= w_missed_sum[7:0];
    end
  end

  assign missed_cnt = r_missed_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
// ============================================================================
// Module      : tb_alarm_sequencer
// Description : Self-checking bench for alarm_sequencer: vector table,
//               directed corner sequences and randomized traffic vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_sequencer;

  localparam int NSL  = 4;
  localparam int SNZ  = 300;
  localparam int RTO  = 60;
  localparam int MAXS = 3;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
  logic       wr_en;
  logic [2:0] wr_slot;
  logic [1:0] wr_h1;
  logic [3:0] wr_h0, wr_m1, wr_m0;
  logic       wr_arm, al_on, stop_al, snooze_req;
  logic       alarm;
  logic [2:0] active_slot;
  logic [1:0] state;
  logic [9:0] snooze_left;
`ifdef ALARM_MISSED_CNT_EN
  logic [7:0] missed_cnt;
`endif

  always #5 clk_1s = ~clk_1s;

  alarm_sequencer #(
    .NUM_SLOTS(NSL), .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(RTO), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk_1s(clk_1s), .reset(reset),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cur_s1(cur_s1), .cur_s0(cur_s0),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_h1(wr_h1), .wr_h0(wr_h0),
    .wr_m1(wr_m1), .wr_m0(wr_m0), .wr_arm(wr_arm),
    .al_on(al_on), .stop_al(stop_al), .snooze_req(snooze_req),
    .alarm(alarm), .active_slot(active_slot), .state(state), .snooze_left(snooze_left)
`ifdef ALARM_MISSED_CNT_EN
    , .missed_cnt(missed_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: slot times held as decimal hhmm, state as 0/1/2.
  int m_state, m_slot, m_left, m_snz, m_elapsed, m_missed;
  int m_arm[8];
  int m_tm[8];

  typedef struct {
    int h, m, s, on;
    int exp_alarm, exp_slot;
  } vec_t;

  function automatic int hhmm(input int a, input int b, input int c, input int d);
    return a * 1000 + b * 100 + c * 10 + d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_slot = 0; m_left = 0; m_snz = 0; m_elapsed = 0; m_missed = 0;
    for (int i = 0; i < 8; i++) begin
      m_arm[i] = 0;
      m_tm[i]  = 0;
    end
  endtask

  task automatic model_step();
    int cur, win;
    cur = hhmm(int'(cur_h1), int'(cur_h0), int'(cur_m1), int'(cur_m0));
    win = -1;
    for (int i = NSL - 1; i >= 0; i--)
      if (m_arm[i] != 0 && m_tm[i] == cur && cur_s1 == 4'd0 && cur_s0 == 4'd0) win = i;
    if (al_on != 1'b1) begin
      m_state = 0;
      m_left  = 0;
    end else if (m_state == 0) begin
      if (win >= 0) begin
        m_state = 1; m_slot = win; m_snz = 0; m_elapsed = 0;
      end
    end else begin
      if (win >= 0) m_missed++;
      if (m_state == 1) begin
        if (stop_al) m_state = 0;
        else if (snooze_req && m_snz < MAXS) begin
          m_state = 2; m_left = SNZ; m_snz++;
        end else if (m_elapsed == RTO - 1) begin
          m_state = 0; m_missed++;
        end else m_elapsed++;
      end else begin
        if (stop_al) begin
          m_state = 0; m_left = 0;
        end else if (m_left == 1) begin
          m_state = 1; m_elapsed = 0; m_left = 0;
        end else m_left--;
      end
    end
    if (m_missed > 255) m_missed = 255;
    if (stop_al) m_missed = 0;
    if (wr_en && int'(wr_slot) < NSL) begin
      m_arm[wr_slot] = int'(wr_arm);
      m_tm[wr_slot]  = hhmm(int'(wr_h1), int'(wr_h0), int'(wr_m1), int'(wr_m0));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_1s);
    #1;
    chk("alarm", int'(alarm), (m_state == 1) ? 1 : 0);
    chk("state", int'(state), m_state);
    chk("active_slot", int'(active_slot), m_slot);
    chk("snooze_left", int'(snooze_left), m_left);
`ifdef ALARM_MISSED_CNT_EN
    chk("missed_cnt", int'(missed_cnt), m_missed);
`endif
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h1 = 2'(h / 10); cur_h0 = 4'(h % 10);
    cur_m1 = 4'(m / 10); cur_m0 = 4'(m % 10);
    cur_s1 = 4'(s / 10); cur_s0 = 4'(s % 10);
  endtask

  task automatic write_slot(input int slot, input int h, input int m, input int arm);
    wr_en = 1'b1; wr_slot = 3'(slot); wr_arm = arm[0];
    wr_h1 = 2'(h / 10); wr_h0 = 4'(h % 10); wr_m1 = 4'(m / 10); wr_m0 = 4'(m % 10);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic stop_event();
    set_time(12, 0, 7);
    stop_al = 1'b1;
    tick();
    stop_al = 1'b0;
    chk("stopped_idle", int'(state), 0);
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    model_reset();
    #2;
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_slot", int'(active_slot), 0);
    chk("rst_left", int'(snooze_left), 0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t vt[9];
    int ph[4];
    int pm[4];
    int p;
    vt[0] = '{7, 30, 0, 1, 1, 1};
    vt[1] = '{7, 30, 15, 1, 0, 0};
    vt[2] = '{7, 30, 0, 0, 0, 0};
    vt[3] = '{6, 0, 0, 1, 1, 0};
    vt[4] = '{23, 59, 0, 1, 1, 3};
    vt[5] = '{12, 0, 0, 1, 0, 0};
    vt[6] = '{7, 31, 0, 1, 0, 0};
    vt[7] = '{10, 0, 0, 1, 0, 0};
    vt[8] = '{23, 59, 59, 1, 0, 0};
    ph = '{6, 7, 5, 23};
    pm = '{0, 30, 0, 59};

    wr_en = 0; wr_slot = 0; wr_h1 = 0; wr_h0 = 0; wr_m1 = 0; wr_m0 = 0; wr_arm = 0;
    al_on = 1; stop_al = 0; snooze_req = 0;
    set_time(12, 0, 5);
    hit_reset();

    write_slot(0, 6, 0, 1);
    write_slot(1, 7, 30, 1);
    write_slot(2, 6, 0, 1);
    write_slot(3, 23, 59, 1);
    write_slot(5, 10, 0, 1);

    for (int i = 0; i < 9; i++) begin
      set_time(vt[i].h, vt[i].m, vt[i].s);
      al_on = vt[i].on[0];
      tick();
      chk("vec_alarm", int'(alarm), vt[i].exp_alarm);
      if (vt[i].exp_alarm != 0) chk("vec_slot", int'(active_slot), vt[i].exp_slot);
      al_on = 1'b1;
      stop_event();
    end

    // Ring on slot 1, stop five ticks later.
    set_time(7, 30, 0);
    tick();
    chk("ring_0730", int'(alarm), 1);
    chk("ring_0730_slot", int'(active_slot), 1);
    set_time(7, 30, 1);
    repeat (4) tick();
    stop_al = 1'b1;
    tick();
    stop_al = 1'b0;
    chk("stop_alarm", int'(alarm), 0);
    chk("stop_state", int'(state), 0);

    // Tie between slots 0 and 2, then a slot 3 match while ringing.
    set_time(6, 0, 0);
    tick();
    chk("tie_slot", int'(active_slot), 0);
    set_time(23, 59, 0);
    tick();
    chk("busy_slot", int'(active_slot), 0);
    chk("busy_alarm", int'(alarm), 1);
    stop_event();

    // Snooze three times; the fourth request is ignored.
    write_slot(3, 5, 0, 1);
    set_time(5, 0, 0);
    tick();
    chk("ring_0500_slot", int'(active_slot), 3);
    set_time(5, 0, 3);
    for (int k = 0; k < MAXS; k++) begin
      snooze_req = 1'b1;
      tick();
      snooze_req = 1'b0;
      chk("snooze_state", int'(state), 2);
      chk("snooze_left_start", int'(snooze_left), SNZ);
      repeat (SNZ - 1) tick();
      chk("snooze_quiet", int'(alarm), 0);
      tick();
      chk("snooze_reRing", int'(alarm), 1);
    end
    snooze_req = 1'b1;
    tick();
    snooze_req = 1'b0;
    chk("snooze_limit_alarm", int'(alarm), 1);
    chk("snooze_limit_state", int'(state), 1);
    stop_event();

    // Unattended ring times out after exactly RTO ticks.
    set_time(7, 30, 0);
    tick();
    set_time(7, 30, 2);
    repeat (RTO - 1) tick();
    chk("timeout_last_ring", int'(alarm), 1);
    tick();
    chk("timeout_drop", int'(alarm), 0);
`ifdef ALARM_MISSED_CNT_EN
    chk("timeout_missed", int'(missed_cnt), 1);
`endif

    // Reset in the middle of a snooze.
    set_time(7, 30, 0);
    tick();
    set_time(7, 30, 4);
    snooze_req = 1'b1;
    tick();
    snooze_req = 1'b0;
    repeat (180) tick();
    chk("mid_snooze_left", int'(snooze_left), 120);
    hit_reset();
    for (int i = 0; i < 4; i++) begin
      set_time(ph[i], pm[i], 0);
      tick();
      chk("disarmed", int'(alarm), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4; i++) write_slot(i, ph[i], pm[i], 1);
    for (int n = 0; n < 1500; n++) begin
      p = int'($urandom_range(0, 3));
      wr_en   = ($urandom_range(0, 19) == 0);
      wr_slot = 3'($urandom_range(0, 7));
      wr_arm  = ($urandom_range(0, 3) != 0);
      wr_h1 = 2'(ph[p] / 10); wr_h0 = 4'(ph[p] % 10);
      wr_m1 = 4'(pm[p] / 10); wr_m0 = 4'(pm[p] % 10);
      p = int'($urandom_range(0, 3));
      set_time(ph[p], pm[p], ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 59)));
      al_on      = ($urandom_range(0, 29) != 0);
      stop_al    = ($urandom_range(0, 39) == 0);
      snooze_req = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Multi-slot alarm controller for the clock datapath.
- Stores NUM_SLOTS programmable alarm times and compares them against the running BCD time each second.
- Arbitrates simultaneous matches by lowest slot index.
- Sequences the ring, snooze, stop and timeout behaviour that drives the Alarm output.

Parameters:
- NUM_SLOTS, 4, number of alarm slots (2..8).
- SNOOZE_SEC, 300, snooze duration in seconds (1..1023).
- RING_TIMEOUT_SEC, 60, maximum ring time before auto-stop (1..255).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7).

Ports:
- clk_1s  in  1  1 Hz tick clock.
- reset  in  1  reset, asynchronous, active-high; clock clk_1s.
- cur_h1  in  2  current hour tens, BCD.
- cur_h0  in  4  current hour units, BCD.
- cur_m1  in  4  current minute tens, BCD.
- cur_m0  in  4  current minute units, BCD.
- cur_s1  in  4  current second tens, BCD.
- cur_s0  in  4  current second units, BCD.
- wr_en  in  1  slot write strobe.
- wr_slot  in  3  slot index to write.
- wr_h1  in  2  write data, hour tens.
- wr_h0  in  4  write data, hour units.
- wr_m1  in  4  write data, minute tens.
- wr_m0  in  4  write data, minute units.
- wr_arm  in  1  write data: slot armed flag.
- al_on  in  1  global alarm enable.
- stop_al  in  1  stop request.
- snooze_req  in  1  snooze request.
- alarm  out  1  ring output.
- active_slot  out  3  slot that owns the current event.
- state  out  2  0 IDLE, 1 RING, 2 SNOOZE.
- snooze_left  out  10  seconds remaining in snooze.

Behaviour:
- Reset values: all slots disarmed with time 00:00; alarm=0; active_slot=0; state=IDLE; snooze_left=0; snooze count=0; ring timer=0.
- Slot write:
  - When wr_en=1 and wr_slot<NUM_SLOTS, the slot is updated at the clk_1s edge.
  - Writes with wr_slot>=NUM_SLOTS are ignored.
  - Writing the active slot does not cancel an event already in progress.
- Match condition, per slot: armed, {h1,h0,m1,m0} equals the current time, and cur_s1=0, cur_s0=0. The block therefore triggers at most once per minute.
- Arbitration: the lowest matching index wins.
- IDLE:
  - If al_on=1 and any slot matches, go to RING on the same edge.
  - On that transition: alarm=1, active_slot=winner, snooze count=0, ring timer=0.
  - The match is evaluated on inputs sampled at that edge, so alarm rises 1 cycle after the time reaches hh:mm:00.
- RING: ring timer increments each tick. Priority order:
  - stop_al → IDLE, alarm=0.
  - Else snooze_req with snooze count<MAX_SNOOZE → SNOOZE, alarm=0, snooze_left=SNOOZE_SEC, snooze count+1.
  - Else ring timer=RING_TIMEOUT_SEC-1 → IDLE, alarm=0.
  - snooze_req at MAX_SNOOZE is ignored (keep ringing).
- SNOOZE:
  - snooze_left decrements each tick.
  - stop_al → IDLE, snooze_left=0.
  - When snooze_left=1, the next edge goes to RING: alarm=1, ring timer=0, snooze_left=0.
- al_on=0 in any state → IDLE, alarm=0, on the next edge. This has the highest priority.
- New matches while in RING or SNOOZE are dropped (no queueing).
- Reset mid-event returns immediately to the reset values.
- BCD inputs are trusted; no range checking is performed.

Optional Feature:
- Macro: ALARM_MISSED_CNT_EN.
- When defined:
  - Adds output missed_cnt[7:0], reset to 0.
  - Increments on each RING→IDLE timeout and on each match dropped while busy.
  - Saturates at 255 and clears on stop_al.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alarm_pkg contains:
  - State encoding constants IDLE/RING/SNOOZE.
  - The BCD time struct type (h1,h0,m1,m0).
  - Default values for SNOOZE_SEC and RING_TIMEOUT_SEC.
- One sub-module: alarm_slot_match. It holds the per-slot registers and the comparator, is instantiated NUM_SLOTS times, and outputs a match bit. The priority encoder and FSM stay in the top level.

Test Plan:
- Program slot 1=07:30 armed, al_on=1, drive time 07:30:00 → alarm=1 and active_slot=1 on the next edge; stop_al 5 ticks later → alarm=0, state=IDLE.
- Slots 0 and 2 both 06:00, time 06:00:00 → active_slot=0; a slot 3 match during RING does not change active_slot.
- Ring at 05:00, snooze_req → state=SNOOZE, snooze_left=300; after 300 ticks alarm=1 again; with MAX_SNOOZE=3, the 4th snooze_req is ignored and alarm stays 1.
- Ring with no stop → alarm drops after exactly 60 ticks; with ALARM_MISSED_CNT_EN, missed_cnt=1.
- Assert reset mid-SNOOZE with snooze_left=120 → alarm=0, state=IDLE, snooze_left=0, all slots disarmed.
- Time 07:30:15 with slot armed at 07:30, or al_on=0 at 07:30:00 → no ring.
